// File: rtl/rob_commit_ctrl_pkg.sv
// Shared ROB commit definitions: geometry, FSM states, mark codes and pointer helpers.
// The ROB itself imports this package so both sides agree on encodings.
package rob_commit_ctrl_pkg;

  localparam int ROB_DEPTH = 64;
  localparam int PTR_W     = $clog2(ROB_DEPTH);
  localparam int PREG_W    = 6;
  localparam int EXC_W     = 6;
  localparam int COMMIT_W  = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_EXC   = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MARK_NORMAL = 2'b00,
    MARK_BREAK  = 2'b01,
    MARK_START  = 2'b10
  } mark_e;

  localparam logic [EXC_W-1:0] EXC_NONE = '0;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  typedef logic [PTR_W:0] ptr_t;

  function automatic ptr_t ptr_add(input ptr_t p, input logic [2:0] n);
    return p + ptr_t'(n);
  endfunction

endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Bundle between the ROB (master: head window, tail, exception ack) and the commit controller (slave).
interface rob_commit_ctrl_if;
  import rob_commit_ctrl_pkg::*;

  logic [PTR_W:0]          TailPtr;
  logic [COMMIT_W-1:0]     WinValid;
  logic [COMMIT_W-1:0]     WinReady;
  logic [4*EXC_W-1:0]      WinExc;
  logic [7:0]              WinMark;
  logic [COMMIT_W-1:0]     WinHasDst;
  logic [4*PREG_W-1:0]     WinPreg;
  logic                    ExcAck;

  logic [PTR_W:0]          HeadPtr;
  logic [2:0]              RetireCnt;
  logic                    RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able;
  logic [PREG_W-1:0]       RetireReg1Addr, RetireReg2Addr, RetireReg3Addr, RetireReg4Addr;
  logic                    FlushReq;
  logic [PTR_W:0]          FlushPtr;
  logic                    ExcReq;
  logic [EXC_W-1:0]        ExcCode;
  logic [PTR_W-1:0]        ExcPtr;

  modport master (
    output TailPtr, WinValid, WinReady, WinExc, WinMark, WinHasDst, WinPreg, ExcAck,
    input  HeadPtr, RetireCnt,
           RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able,
           RetireReg1Addr, RetireReg2Addr, RetireReg3Addr, RetireReg4Addr,
           FlushReq, FlushPtr, ExcReq, ExcCode, ExcPtr
  );

  modport slave (
    input  TailPtr, WinValid, WinReady, WinExc, WinMark, WinHasDst, WinPreg, ExcAck,
    output HeadPtr, RetireCnt,
           RetireReg1Able, RetireReg2Able, RetireReg3Able, RetireReg4Able,
           RetireReg1Addr, RetireReg2Addr, RetireReg3Addr, RetireReg4Addr,
           FlushReq, FlushPtr, ExcReq, ExcCode, ExcPtr
  );

endinterface

// File: rtl/rob_commit_ctrl_select.sv
// Combinational head-window scan: finds the in-order run of committable slots and
// reports whether the run ended on a BREAK entry or on a faulting entry.
module rob_commit_ctrl_select
  import rob_commit_ctrl_pkg::*;
(
  input  ptr_t                occupancy,
  input  logic [COMMIT_W-1:0] win_valid,
  input  logic [COMMIT_W-1:0] win_ready,
  input  logic [4*EXC_W-1:0]  win_exc,
  input  logic [7:0]          win_mark,
  output logic [COMMIT_W-1:0] commit_mask,
  output logic [2:0]          commit_cnt,
  output logic                break_hit,
  output logic                exc_hit,
  output logic [1:0]          exc_slot
);

  logic scan_open;

  always_comb begin
    commit_mask = '0;
    commit_cnt  = '0;
    break_hit   = 1'b0;
    exc_hit     = 1'b0;
    exc_slot    = '0;
    scan_open   = 1'b1;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (scan_open) begin
        if ((ptr_t'(i) < occupancy) && win_valid[i] && win_ready[i]) begin
          if (win_exc[i*EXC_W +: EXC_W] != EXC_NONE) begin
            exc_hit   = 1'b1;
            exc_slot  = 2'(i);
            scan_open = 1'b0;
          end else begin
            commit_mask[i] = 1'b1;
            commit_cnt     = commit_cnt + 3'd1;
            // A BREAK commits itself but closes the window for younger entries.
            if (win_mark[2*i +: 2] == MARK_BREAK) begin
              break_hit = 1'b1;
              scan_open = 1'b0;
            end
          end
        end else begin
          scan_open = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// In-order ROB commit controller: retires up to four entries per cycle, advances the head,
// and sequences flushes for BREAK entries and for acknowledged exceptions.
module rob_commit_ctrl
  import rob_commit_ctrl_pkg::*;
(
  input  logic             Clk,
  input  logic             Rest,
  rob_commit_ctrl_if.slave bus
);

  state_e                           state_q, state_d;
  ptr_t                             head_q, head_d;
  logic [2:0]                       retire_cnt_q, retire_cnt_d;
  logic [COMMIT_W-1:0]              able_q, able_d;
  logic [COMMIT_W-1:0][PREG_W-1:0]  addr_q, addr_d;
  logic                             flush_req_q, flush_req_d;
  ptr_t                             flush_ptr_q, flush_ptr_d;
  logic                             exc_req_q, exc_req_d;
  logic [EXC_W-1:0]                 exc_code_q, exc_code_d;
  logic [PTR_W-1:0]                 exc_ptr_q, exc_ptr_d;

  ptr_t                occupancy;
  ptr_t                exc_abs;
  logic [COMMIT_W-1:0] commit_mask;
  logic [2:0]          commit_cnt;
  logic                break_hit;
  logic                exc_hit;
  logic [1:0]          exc_slot;

  assign occupancy = bus.TailPtr - head_q;
  assign exc_abs   = head_q + ptr_t'(exc_slot);

  rob_commit_ctrl_select u_select (
    .occupancy   (occupancy),
    .win_valid   (bus.WinValid),
    .win_ready   (bus.WinReady),
    .win_exc     (bus.WinExc),
    .win_mark    (bus.WinMark),
    .commit_mask (commit_mask),
    .commit_cnt  (commit_cnt),
    .break_hit   (break_hit),
    .exc_hit     (exc_hit),
    .exc_slot    (exc_slot)
  );

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q      <= ST_RUN;
      head_q       <= '0;
      retire_cnt_q <= '0;
      able_q       <= '0;
      addr_q       <= '0;
      flush_req_q  <= 1'b0;
      flush_ptr_q  <= '0;
      exc_req_q    <= 1'b0;
      exc_code_q   <= '0;
      exc_ptr_q    <= '0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      retire_cnt_q <= retire_cnt_d;
      able_q       <= able_d;
      addr_q       <= addr_d;
      flush_req_q  <= flush_req_d;
      flush_ptr_q  <= flush_ptr_d;
      exc_req_q    <= exc_req_d;
      exc_code_q   <= exc_code_d;
      exc_ptr_q    <= exc_ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (break_hit)    state_d = ST_FLUSH;
        else if (exc_hit) state_d = ST_EXC;
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_EXC:   if (bus.ExcAck) state_d = ST_FLUSH;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    head_d       = head_q;
    retire_cnt_d = '0;
    able_d       = '0;
    addr_d       = '0;
    flush_req_d  = 1'b0;
    flush_ptr_d  = flush_ptr_q;
    exc_req_d    = exc_req_q;
    exc_code_d   = exc_code_q;
    exc_ptr_d    = exc_ptr_q;
    unique case (state_q)
      ST_RUN: begin
        head_d       = ptr_add(head_q, commit_cnt);
        retire_cnt_d = commit_cnt;
        // Committed slots are always a prefix, so retire port k maps to window slot k.
        for (int k = 0; k < COMMIT_W; k++) begin
          if (commit_mask[k]) begin
            able_d[k] = bus.WinHasDst[k];
            addr_d[k] = bus.WinPreg[k*PREG_W +: PREG_W];
          end
        end
        if (exc_hit) begin
          exc_req_d  = 1'b1;
          exc_code_d = bus.WinExc[exc_slot*EXC_W +: EXC_W];
          exc_ptr_d  = exc_abs[PTR_W-1:0];
        end
      end
      ST_FLUSH: begin
        // Head already sits on the first squashed entry (past the BREAK, or on the faulting one).
        flush_req_d = 1'b1;
        flush_ptr_d = head_q;
      end
      ST_EXC: begin
        if (bus.ExcAck) exc_req_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.HeadPtr        = head_q;
  assign bus.RetireCnt      = retire_cnt_q;
  assign bus.RetireReg1Able = able_q[0];
  assign bus.RetireReg2Able = able_q[1];
  assign bus.RetireReg3Able = able_q[2];
  assign bus.RetireReg4Able = able_q[3];
  assign bus.RetireReg1Addr = addr_q[0];
  assign bus.RetireReg2Addr = addr_q[1];
  assign bus.RetireReg3Addr = addr_q[2];
  assign bus.RetireReg4Addr = addr_q[3];
  assign bus.FlushReq       = flush_req_q;
  assign bus.FlushPtr       = flush_ptr_q;
  assign bus.ExcReq         = exc_req_q;
  assign bus.ExcCode        = exc_code_q;
  assign bus.ExcPtr         = exc_ptr_q;

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
In-order commit scheduler for the 64-entry reorder buffer. Each cycle it examines the four oldest ROB entries (head window) and retires up to four consecutive completed entries. It drives the retire-register interface to the physical register file and advances the head pointer. It sequences pipeline flushes on branch/LSU backtrack (BREAK) entries and on exceptions.

Parameters:
ROB_DEPTH, 64, ROB entries (power of two)
PTR_W, 6, entry index width (log2 ROB_DEPTH)
PREG_W, 6, physical register address width
EXC_W, 6, exception code width; 0 = no exception
COMMIT_W, 4, max retires per cycle (fixed at 4)

Ports:
Clk  in  1  clock
Rest  in  1  synchronous reset, active-high
TailPtr  in  PTR_W+1  ROB allocation pointer incl. wrap bit
WinValid  in  4  entry valid, slot i = entry HeadPtr+i
WinReady  in  4  execution complete
WinExc  in  4*EXC_W  exception code per slot, slot0 in LSBs
WinMark  in  8  2-bit start/break mark per slot (01 = BREAK, 10 = START, 00 = NORMAL)
WinHasDst  in  4  entry writes a destination register
WinPreg  in  4*PREG_W  old physical register to free, per slot
ExcAck  in  1  exception/CSR unit accepted exception
HeadPtr  out  PTR_W+1  oldest-entry pointer incl. wrap bit
RetireCnt  out  3  entries retired this cycle (0..4)
RetireReg1Able..RetireReg4Able  out  1 each  free-register strobe
RetireReg1Addr..RetireReg4Addr  out  PREG_W each  register to free
FlushReq  out  1  one-cycle pulse: squash all entries younger than the retire point
FlushPtr  out  PTR_W+1  new tail (first squashed entry) on flush
ExcReq  out  1  exception pending, held until ExcAck
ExcCode  out  EXC_W  code of faulting entry
ExcPtr  out  PTR_W  index of faulting entry

Behaviour:
- Reset (Rest=1 at a Clk edge): HeadPtr=0; RetireCnt=0; all RetireRegNAble=0 and Addr=0; FlushReq=0; FlushPtr=0; ExcReq=0; ExcCode=0; ExcPtr=0; state=RUN. Reset mid-flush or mid-exception aborts to RUN with no pulse.
- Occupancy = TailPtr - HeadPtr (PTR_W+1-bit modular); slot i is eligible only if i < occupancy. Empty (HeadPtr==TailPtr) retires nothing.
- Slot i is committable if all of the following hold: eligible, WinValid[i], WinReady[i], WinExc[i]==0, and all slots j<i committed. No gaps are allowed.
- A BREAK slot that is committable commits, and younger slots in the same window are not committed that cycle.
- FSM states: RUN, FLUSH, EXC.
- RUN:
  - Commit n slots. HeadPtr += n at the edge, wrapping at 2^(PTR_W+1).
  - Retire outputs are registered (1-cycle latency from the window). RetireRegkAble=WinHasDst of the k-th committed slot; unused slots drive Able=0.
  - Committed BREAK slot -> FLUSH.
  - First non-committed eligible slot that is valid, ready, and has WinExc!=0 -> EXC. ExcReq=1 next cycle; ExcCode/ExcPtr latched. That slot does not retire; slots before it do.
- FLUSH: one cycle. FlushReq=1 and FlushPtr=current HeadPtr (already past the break entry). No commits. Return to RUN next cycle.
- EXC: no commits. ExcReq/ExcCode/ExcPtr held stable. On ExcAck=1: ExcReq=0 next cycle, FlushPtr=HeadPtr (faulting entry squashed, not retired), then FLUSH-equivalent pulse, then RUN. ExcAck outside EXC is ignored.
- Not-ready slot 0 stalls commit entirely (RetireCnt=0), with no state change.
- Window wrap (HeadPtr near 63) is handled by the ROB. The controller only does pointer arithmetic modulo 2^(PTR_W+1).

Decomposition:
- Shared package/define header: FSM state encodings (RUN=2'd0, FLUSH=2'd1, EXC=2'd2), mark codes (BREAK/START/NORMAL), EXC_NONE=0, ROB depth and pointer widths. The ROB uses the same definitions.
- One sub-module: rob_commit_select, combinational. Takes the window plus occupancy and produces the commit mask, count, break-hit, exception-hit and exception-slot index. The FSM and output registers stay in the top.

Test Plan:
- Reset, then TailPtr=4 and all 4 slots valid+ready, WinHasDst=1111, Preg=5,6,7,8 -> next cycle RetireCnt=4, Able=1111, Addr=5,6,7,8, and HeadPtr=4.
- Slots ready=1011 -> RetireCnt=2 (slots 0,1 only) and HeadPtr+=2. Slot 3 waits despite being ready.
- HeadPtr=62, TailPtr=66 (wrapped), all ready -> RetireCnt=4 and HeadPtr=66 (7-bit: 0b1000010).
- Slot1 WinMark=01 (BREAK), all ready -> RetireCnt=2, then next cycle FlushReq=1 for exactly one cycle with FlushPtr=HeadPtr, and RetireCnt=0 during the flush.
- Slot2 WinExc=6'h0A -> RetireCnt=2, then ExcReq=1, ExcCode=0x0A, ExcPtr=head+2. ExcReq stays held for 5 cycles with no retires; ExcAck -> ExcReq=0, FlushReq pulse with FlushPtr=faulting index.
- Rest=1 asserted while in EXC -> next cycle all outputs are at their reset values, and after release with occupancy=0 there are no retires and no FlushReq.
